hamming128_decoder: RTL and testbench

HAMMING128_DECODER -- requirements
Module: hamming128_decoder

---
 rtl/hamming_pkg.sv | 22 ++
 rtl/hamming128_decoder_if.sv | 29 ++
 rtl/hamming74_corrector.sv | 38 +++
 rtl/hamming128_decoder.sv | 123 ++++++++++++
 tb/tb_hamming128_decoder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared widths and FSM state encoding for the 128-bit Hamming(7,4) decoder.
//   GROUP_W    : bits per encoded group (d3..d0, p0, p1, p2)
//   DATA_W     : data bits per group
//   NUM_GROUPS : groups per codeword
//   CODE_W     : encoded codeword width
//   DATA_OUT_W : decoded data width
package hamming_pkg;

  localparam int GROUP_W    = 7;
  localparam int DATA_W     = 4;
  localparam int NUM_GROUPS = 32;
  localparam int CODE_W     = GROUP_W * NUM_GROUPS;
  localparam int DATA_OUT_W = DATA_W * NUM_GROUPS;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/hamming128_decoder_if.sv
// Handshake bundle between the codeword source/result sink and the decoder.
//   in_valid/in_ready/encoded_in          : codeword input handshake
//   out_valid/out_ready/data_out,
//   err_count/err_flag                    : result output handshake
// master: source/sink side (testbench or upstream logic)
// slave : the decoder
interface hamming128_decoder_if;
  import hamming_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [CODE_W-1:0]      encoded_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_OUT_W-1:0]  data_out;
  logic [CNT_W-1:0]       err_count;
  logic                   err_flag;

  modport master (
    output in_valid, encoded_in, out_ready,
    input  in_ready, out_valid, data_out, err_count, err_flag
  );

  modport slave (
    input  in_valid, encoded_in, out_ready,
    output in_ready, out_valid, data_out, err_count, err_flag
  );

endinterface

// File: rtl/hamming74_corrector.sv
// Combinational single-error corrector for one Hamming(7,4) group.
//   group_in : [3:0] = d3..d0, [4] = p0, [5] = p1, [6] = p2
//   data_out : corrected d3..d0
//   syndrome : {s2, s1, s0}
//   err      : syndrome is nonzero
module hamming74_corrector
  import hamming_pkg::*;
(
  input  logic [GROUP_W-1:0] group_in,
  output logic [DATA_W-1:0]  data_out,
  output logic [2:0]         syndrome,
  output logic               err
);

  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] flip;

  always_comb begin
    d = group_in[3:0];
    syndrome[0] = group_in[4] ^ d[0] ^ d[1] ^ d[3];
    syndrome[1] = group_in[5] ^ d[0] ^ d[2] ^ d[3];
    syndrome[2] = group_in[6] ^ d[1] ^ d[2] ^ d[3];

    // Single-bit syndromes point at a parity bit, which carries no data.
    flip = '0;
    case (syndrome)
      3'b011:  flip = 4'b0001;
      3'b101:  flip = 4'b0010;
      3'b110:  flip = 4'b0100;
      3'b111:  flip = 4'b1000;
      default: flip = 4'b0000;
    endcase

    data_out = d ^ flip;
    err      = |syndrome;
  end

endmodule

// File: rtl/hamming128_decoder.sv
// Multi-cycle 128-bit Hamming(7,4) decoder. A 224-bit codeword is captured,
// GROUPS_PER_CYCLE groups are corrected per cycle, and the corrected data plus
// the count of groups with a nonzero syndrome are presented until consumed.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of hamming128_decoder_if (codeword in, result out)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | in_ready=1, waiting for a codeword
// DECODE | correcting GROUPS_PER_CYCLE groups per cycle
// DONE   | out_valid=1, result held until out_ready
module hamming128_decoder
  import hamming_pkg::*;
#(
  parameter int GROUPS_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  hamming128_decoder_if.slave bus
);

  localparam int G        = GROUPS_PER_CYCLE;
  localparam int SLICE_DW = G * DATA_W;
  localparam int SLICE_CW = G * GROUP_W;

  state_e                  state_q, state_d;
  logic [CODE_W-1:0]       hold_q, hold_d;
  logic [DATA_OUT_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]        grp_idx_q, grp_idx_d;
  logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;

  logic [SLICE_DW-1:0]     slice_data;
  logic [G-1:0]            slice_err;
  logic [2:0]              slice_syn_unused [G];
  logic [CNT_W-1:0]        slice_err_cnt;
  logic [CNT_W:0]          err_sum;

  // The holding register shifts down one slice per DECODE cycle, so the
  // correctors always look at its bottom slice instead of a muxed window.
  for (genvar g = 0; g < G; g++) begin : g_corr
    hamming74_corrector u_corr (
      .group_in (hold_q[g*GROUP_W +: GROUP_W]),
      .data_out (slice_data[g*DATA_W +: DATA_W]),
      .syndrome (slice_syn_unused[g]),
      .err      (slice_err[g])
    );
  end

  always_comb begin
    slice_err_cnt = '0;
    for (int g = 0; g < G; g++) begin
      slice_err_cnt = slice_err_cnt + CNT_W'(slice_err[g]);
    end
    err_sum = {1'b0, err_cnt_q} + {1'b0, slice_err_cnt};
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    data_d    = data_q;
    grp_idx_d = grp_idx_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          hold_d    = bus.encoded_in;
          data_d    = '0;
          grp_idx_d = '0;
          err_cnt_d = '0;
          state_d   = DECODE;
        end
      end

      DECODE: begin
        hold_d = hold_q >> SLICE_CW;
        // Corrected slice enters at the top; after the last cycle group 0
        // has been shifted down to bits [3:0].
        data_d = (data_q >> SLICE_DW)
               | (DATA_OUT_W'(slice_data) << (DATA_OUT_W - SLICE_DW));
        grp_idx_d = grp_idx_q + CNT_W'(G);
        // Saturate rather than wrap; with 32 groups the clamp never engages.
        err_cnt_d = (err_sum > (CNT_W+1)'(NUM_GROUPS)) ? CNT_W'(NUM_GROUPS)
                                                      : err_sum[CNT_W-1:0];
        if (grp_idx_q == CNT_W'(NUM_GROUPS - G)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      data_q    <= '0;
      grp_idx_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      data_q    <= data_d;
      grp_idx_q <= grp_idx_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.data_out  = data_q;
  assign bus.err_count = err_cnt_q;
  assign bus.err_flag  = |err_cnt_q;

endmodule

// File: tb/tb_hamming128_decoder.sv
// Scoreboard bench for hamming128_decoder: the driver pushes the expected
// result of each codeword; a monitor pops and compares on every accepted
// output.
module tb_hamming128_decoder;
  import hamming_pkg::*;

  typedef struct packed {
    logic [127:0] d;
    logic [5:0]   c;
  } exp_t;

  localparam logic [127:0] K = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  hamming128_decoder_if bus_if ();

  hamming128_decoder #(.GROUPS_PER_CYCLE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference encoder for the group format: [3:0]=d, 4=p0, 5=p1, 6=p2.
  function automatic logic [223:0] enc(input logic [127:0] data);
    logic [223:0] c;
    logic [3:0]   dd;
    c = '0;
    for (int g = 0; g < 32; g++) begin
      dd = data[4*g +: 4];
      c[7*g +: 7] = {dd[1]^dd[2]^dd[3], dd[0]^dd[2]^dd[3], dd[0]^dd[1]^dd[3], dd};
    end
    return c;
  endfunction

  // Monitor: compares every accepted result against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 128'(bus_if.out_valid), 128'(0));
      end else begin
        e = sb.pop_front();
        chk("data_out", bus_if.data_out, e.d);
        chk("err_count", 128'(bus_if.err_count), 128'(e.c));
        chk("err_flag", 128'(bus_if.err_flag), 128'(e.c != 0));
      end
    end
  end

  task automatic send(input string name, input logic [223:0] code,
                      input logic [127:0] exp_d, input logic [5:0] exp_c,
                      input bit stall);
    exp_t e;
    int   n;
    bit   seen;
    @(posedge clk); #2;
    if (stall) bus_if.out_ready = 1'b0;
    bus_if.in_valid   = 1'b1;
    bus_if.encoded_in = code;
    e.d = exp_d;
    e.c = exp_c;
    sb.push_back(e);
    @(posedge clk); #1;
    chk({name, "_in_ready_busy"}, 128'(bus_if.in_ready), 128'(0));
    #1;
    bus_if.in_valid   = 1'b0;
    bus_if.encoded_in = ~code;  // must be ignored outside IDLE
    n = 1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus_if.out_valid) seen = 1'b1;
    end
    chk({name, "_latency"}, 128'(n), 128'(9));
    if (stall) begin
      repeat (5) begin
        @(negedge clk);
        chk({name, "_hold_valid"}, 128'(bus_if.out_valid), 128'(1));
        chk({name, "_hold_in_ready"}, 128'(bus_if.in_ready), 128'(0));
        chk({name, "_hold_data"}, bus_if.data_out, exp_d);
        chk({name, "_hold_cnt"}, 128'(bus_if.err_count), 128'(exp_c));
      end
      @(posedge clk); #2;
      bus_if.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({name, "_back_idle"}, 128'({bus_if.in_ready, bus_if.out_valid}), 128'(2'b10));
  endtask

  initial begin
    logic [223:0] c;
    int           ov;

    bus_if.in_valid   = 1'b0;
    bus_if.encoded_in = '0;
    bus_if.out_ready  = 1'b1;
    #1;
    chk("rst_in_ready", 128'(bus_if.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus_if.out_valid), 128'(0));
    chk("rst_data", bus_if.data_out, 128'(0));
    chk("rst_err_count", 128'(bus_if.err_count), 128'(0));
    chk("rst_err_flag", 128'(bus_if.err_flag), 128'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    send("zero", '0, 128'(0), 6'd0, 1'b0);

    c = enc(K); c[0] = ~c[0];
    send("d0_g0", c, K, 6'd1, 1'b0);

    c = enc(K); c[6] = ~c[6]; c[223] = ~c[223];
    send("p2_g0_g31", c, K, 6'd2, 1'b0);

    c = '1;
    for (int g = 0; g < 32; g++) c[7*g + (g % 4)] = ~c[7*g + (g % 4)];
    send("ones_all_err", c, {128{1'b1}}, 6'd32, 1'b0);

    send("clean", enc(K), K, 6'd0, 1'b0);

    c = enc(K); c[38] = ~c[38]; c[72] = ~c[72]; c[145] = ~c[145];
    send("three_err", c, K, 6'd3, 1'b0);

    // d0 and d1 both flipped: syndrome 110 miscorrects d2 -> data 4'h7.
    c = '0; c[0] = 1'b1; c[1] = 1'b1;
    send("double_err", c, 128'h7, 6'd1, 1'b0);

    c = enc(~K); c[200] = ~c[200];
    send("stall", c, ~K, 6'd1, 1'b1);

    // Reset in the fourth DECODE cycle discards the codeword.
    @(posedge clk); #2;
    bus_if.in_valid   = 1'b1;
    bus_if.encoded_in = '1;
    @(posedge clk); #2;
    bus_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 128'(bus_if.in_ready), 128'(1));
    chk("midrst_out_valid", 128'(bus_if.out_valid), 128'(0));
    chk("midrst_data", bus_if.data_out, 128'(0));
    chk("midrst_err_count", 128'(bus_if.err_count), 128'(0));
    chk("midrst_err_flag", 128'(bus_if.err_flag), 128'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    ov = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.out_valid) ov++;
    end
    chk("midrst_no_valid", 128'(ov), 128'(0));

    c = enc(K); c[100] = ~c[100];
    send("after_rst", c, K, 6'd1, 1'b0);

    repeat (2) @(posedge clk);
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
